// File: rtl/seg_scan_capture.sv
// Monitors a multiplexed active-low 7-segment display bus and recovers the hex digit
// shown on each anode position, flagging non-hex glyphs and framing complete scans.
module seg_scan_capture #(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned STABLE_CYC  = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_DIGITS-1:0]   an_n,
   input  logic [6:0]              seg_n,
   input  logic                    clr,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   digit_vld,
   output logic [NUM_DIGITS-1:0]   digit_err,
   output logic                    frame_vld,
   output logic [4*NUM_DIGITS-1:0] frame
);

   localparam int unsigned PW = NUM_DIGITS + 7;
   localparam int unsigned CW = $clog2(STABLE_CYC);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);

   logic [SYNC_STAGES*PW-1:0] sync_q;
   logic [PW-1:0]             pair_cur;
   logic [PW-1:0]             prev_q, prev_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic                      armed_q, armed_d;

   logic [4*NUM_DIGITS-1:0]   digits_q, digits_d;
   logic [NUM_DIGITS-1:0]     vld_q, vld_d;
   logic [NUM_DIGITS-1:0]     err_q, err_d;
   logic [NUM_DIGITS-1:0]     seen_q, seen_d;
   logic                      frame_vld_q, frame_vld_d;
   logic [4*NUM_DIGITS-1:0]   frame_q, frame_d;

   logic [NUM_DIGITS-1:0]     prev_an;
   logic [6:0]                prev_seg;
   logic                      changed;
   logic                      window_end;
   logic                      any_low;
   logic                      multi_low;
   logic                      capture;
   logic                      hex_ok;
   logic [3:0]                nib;

   assign pair_cur = sync_q[SYNC_STAGES*PW-1 -: PW];
   assign prev_an  = prev_q[PW-1:7];
   assign prev_seg = prev_q[6:0];

   // Segment glyph to nibble; anything else (including blank) is not a hex glyph.
   always_comb begin
      hex_ok = 1'b1;
      nib    = 4'h0;
      case (prev_seg)
         7'b0000001: nib = 4'h0;
         7'b1001111: nib = 4'h1;
         7'b0010010: nib = 4'h2;
         7'b0000110: nib = 4'h3;
         7'b1001100: nib = 4'h4;
         7'b0100100: nib = 4'h5;
         7'b0100000: nib = 4'h6;
         7'b0001111: nib = 4'h7;
         7'b0000000: nib = 4'h8;
         7'b0000100: nib = 4'h9;
         7'b0001000: nib = 4'hA;
         7'b1100000: nib = 4'hB;
         7'b0110001: nib = 4'hC;
         7'b1000010: nib = 4'hD;
         7'b0110000: nib = 4'hE;
         7'b0111000: nib = 4'hF;
         default:    hex_ok = 1'b0;
      endcase
   end

   always_comb begin
      any_low   = 1'b0;
      multi_low = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!prev_an[i]) begin
            if (any_low) multi_low = 1'b1;
            any_low = 1'b1;
         end
      end
   end

   assign changed    = (pair_cur != prev_q);
   // Capture judges the window that just completed, so it looks at prev_q, not pair_cur.
   assign window_end = armed_q && (cnt_q == CNT_MAX);
   assign capture    = window_end && any_low && !multi_low && !clr;

   always_comb begin
      prev_d = pair_cur;
      if (changed) begin
         cnt_d   = '0;
         armed_d = 1'b1;
      end else begin
         cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
         armed_d = window_end ? 1'b0 : armed_q;
      end
   end

   always_comb begin
      digits_d    = digits_q;
      vld_d       = vld_q;
      err_d       = err_q;
      seen_d      = seen_q;
      frame_vld_d = 1'b0;
      frame_d     = frame_q;
      if (&seen_q) begin
         frame_vld_d = 1'b1;
         frame_d     = digits_q;
         seen_d      = '0;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (capture && !prev_an[i]) begin
            if (hex_ok) begin
               digits_d[4*i +: 4] = nib;
               vld_d[i]           = 1'b1;
               seen_d[i]          = 1'b1;
            end else begin
               err_d[i] = 1'b1;
            end
         end
      end
      if (clr) begin
         digits_d = '0;
         vld_d    = '0;
         err_d    = '0;
         seen_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= '1;
         prev_q      <= '1;
         cnt_q       <= '0;
         armed_q     <= 1'b0;
         digits_q    <= '0;
         vld_q       <= '0;
         err_q       <= '0;
         seen_q      <= '0;
         frame_vld_q <= 1'b0;
         frame_q     <= '0;
      end else begin
         sync_q      <= {sync_q[(SYNC_STAGES-1)*PW-1:0], an_n, seg_n};
         prev_q      <= prev_d;
         cnt_q       <= cnt_d;
         armed_q     <= armed_d;
         digits_q    <= digits_d;
         vld_q       <= vld_d;
         err_q       <= err_d;
         seen_q      <= seen_d;
         frame_vld_q <= frame_vld_d;
         frame_q     <= frame_d;
      end
   end

   assign digits    = digits_q;
   assign digit_vld = vld_q;
   assign digit_err = err_q;
   assign frame_vld = frame_vld_q;
   assign frame     = frame_q;

endmodule
